uart_loader: RTL

- Boot-time program loader between the UART byte receiver (RX_DATA/RX_DONE) and the instruction memory write port of the RISC-V core.
- Parses a framed byte stream: sync, word count, little-endian 32-bit words, checksum.
- Writes each assembled word to consecutive word addresses.
- Holds the CPU in reset until a load completes with a matching checksum.

---
 rtl/uart_loader_if.sv | 27 ++
 rtl/uart_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_loader_if.sv
// Byte-receiver and instruction-memory write bus of the boot loader.
// The master modport is the loader side; the slave modport is the UART/memory side.
interface uart_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            RX_DATA;
    logic                  RX_DONE;
    logic                  MEM_WE;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [31:0]           MEM_WDATA;

    modport master (
        input  RX_DATA,
        input  RX_DONE,
        output MEM_WE,
        output MEM_ADDR,
        output MEM_WDATA
    );

    modport slave (
        output RX_DATA,
        output RX_DONE,
        input  MEM_WE,
        input  MEM_ADDR,
        input  MEM_WDATA
    );
endinterface

// File: rtl/uart_loader.sv
// Boot loader: parses SYNC / N_LO / N_HI / 4*N data bytes / CSUM from the UART
// and writes little-endian words to instruction memory, holding the CPU in reset until a clean load.
module uart_loader #(
    parameter int          ADDR_WIDTH   = 10,
    parameter int          BASE_ADDR    = 0,
    parameter int          TIMEOUT_CLKS = 1000000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    uart_loader_if.master bus,
    output logic          CPU_RESET,
    output logic          LOAD_DONE,
    output logic          LOAD_ERR,
    output logic          BUSY
);

    localparam int          TMO_W     = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    localparam int unsigned MAX_WORDS = (32'd1 << ADDR_WIDTH) - 32'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [31:0]           word_q, word_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic                  busy_q, busy_d;

    logic [15:0]           n_full;
    logic                  timeout;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            byte_idx_q  <= '0;
            word_idx_q  <= '0;
            csum_q      <= '0;
            word_q      <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            csum_q      <= csum_d;
            word_q      <= word_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            busy_q      <= busy_d;
        end
    end

    assign n_full  = {bus.RX_DATA, len_q[7:0]};
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout = (state_q != S_IDLE) && !bus.RX_DONE && (tmo_q == TMO_LAST);

    // NOTE: every _d signal gets a default before the case statement so no
    // path through the block leaves a variable unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        csum_d      = csum_q;
        word_d      = word_q;
        tmo_d       = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_reset_d = cpu_reset_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;

        if (state_q != S_IDLE) begin
            tmo_d = bus.RX_DONE ? '0 : tmo_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.RX_DONE && bus.RX_DATA == SYNC_BYTE) begin
                    state_d     = S_LEN_LO;
                    cpu_reset_d = 1'b1;
                    load_err_d  = 1'b0;
                    csum_d      = '0;
                    byte_idx_d  = '0;
                    word_idx_d  = '0;
                end
            end
            S_LEN_LO: begin
                if (bus.RX_DONE) begin
                    len_d[7:0] = bus.RX_DATA;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (bus.RX_DONE) begin
                    len_d[15:8] = bus.RX_DATA;
                    if (n_full == 16'd0 || 32'(n_full) > MAX_WORDS) begin
                        state_d    = S_IDLE;
                        load_err_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.RX_DONE) begin
                    word_d[8*byte_idx_q +: 8] = bus.RX_DATA;
                    csum_d     = csum_q + bus.RX_DATA;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ADDR_WIDTH'(32'(BASE_ADDR) + 32'(word_idx_q));
                        mem_wdata_d = {bus.RX_DATA, word_q[23:0]};
                        word_idx_d  = word_idx_q + 16'd1;
                        if (word_idx_q == len_q - 16'd1) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (bus.RX_DONE) begin
                    state_d = S_IDLE;
                    if (bus.RX_DATA == csum_q) begin
                        load_done_d = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d     = S_IDLE;
            load_err_d  = 1'b1;
            cpu_reset_d = 1'b1;
        end

        if (state_d == S_IDLE) begin
            tmo_d = '0;
        end
        busy_d = (state_d != S_IDLE);
    end

    assign bus.MEM_WE    = mem_we_q;
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.MEM_WDATA = mem_wdata_q;
    assign CPU_RESET     = cpu_reset_q;
    assign LOAD_DONE     = load_done_q;
    assign LOAD_ERR      = load_err_q;
    assign BUSY          = busy_q;

endmodule
